// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-0 master that turns one level-handshaked core request
// into one READ/WRITE transaction on flash (cs1) or RAM (cs2), SPI clock = clk/2.
// Optional feature: define SPI_FAST_READ_EN for FAST READ (0x0B + 8 dummy bits) on reads.
module spi_mem_bridge #(
  parameter int unsigned ADDRESS_SIZE = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_request,
  input  logic                    is_write,
  input  logic [2:0]              num_bytes,
  input  logic [ADDRESS_SIZE-1:0] target_address,
  input  logic [31:0]             write_value,
  output logic [31:0]             fetched_value,
  output logic                    request_done,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    cs1,
  output logic                    cs2,
  input  logic                    miso
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCmd    = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StDummy  = 3'd3;
  localparam logic [2:0] StData   = 3'd4;
  localparam logic [2:0] StFinish = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

`ifdef SPI_FAST_READ_EN
  localparam logic       FastRead = 1'b1;
  localparam logic [7:0] RdOp     = 8'h0B;
`else
  localparam logic       FastRead = 1'b0;
  localparam logic [7:0] RdOp     = 8'h03;
`endif
  localparam logic [7:0] WrOp = 8'h02;

  logic [2:0]  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        phase_q, phase_d;      // 0: sclk low half, 1: sclk high half
  logic [71:0] sh_q, sh_d;            // whole outgoing bit stream, MSB is on mosi
  logic        is_write_q, is_write_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        chip_q, chip_d;        // 0 = flash/cs1, 1 = RAM/cs2
  logic [31:0] fv_q, fv_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        cs1_q, cs1_d;
  logic        cs2_q, cs2_d;

  logic [2:0]  nb_clamp;
  logic [23:0] addr24;
  logic [31:0] wr_bytes;
  logic [31:0] wr_mask;
  logic [5:0]  bit_len;
  logic        cs_active;

  // Request decode, bit sequencing and next-state logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    sh_d       = sh_q;
    is_write_d = is_write_q;
    nbytes_d   = nbytes_q;
    chip_d     = chip_q;
    fv_d       = fv_q;
    done_d     = done_q;
    sclk_d     = sclk_q;

    nb_clamp = (num_bytes > 3'd4) ? 3'd4 : num_bytes;
    addr24   = 24'(target_address[ADDRESS_SIZE-2:0]);
    wr_bytes = {write_value[7:0], write_value[15:8], write_value[23:16], write_value[31:24]};
    // Keep only the first n bytes so mosi returns to 0 once they are sent.
    wr_mask  = ~(32'hFFFF_FFFF >> {nb_clamp, 3'b000});

    unique case (state_q)
      StCmd:   bit_len = 6'd8;
      StAddr:  bit_len = 6'd24;
      StDummy: bit_len = 6'd8;
      default: bit_len = {nbytes_q, 3'b000};
    endcase

    unique case (state_q)
      StIdle: begin
        if (start_request && !done_q) begin
          is_write_d = is_write;
          nbytes_d   = nb_clamp;
          chip_d     = target_address[ADDRESS_SIZE-1];
          fv_d       = 32'h0;
          phase_d    = 1'b0;
          bit_cnt_d  = 6'd0;
          sclk_d     = 1'b0;
          if (nb_clamp == 3'd0) begin
            state_d = StFinish;
          end else begin
            state_d = StCmd;
            sh_d    = is_write ? {WrOp, addr24, wr_bytes & wr_mask, 8'h00}
                               : {RdOp, addr24, 40'h0};
          end
        end
      end
      StCmd, StAddr, StDummy, StData: begin
        if (state_q == StData && !phase_q && bit_cnt_q == bit_len) begin
          // Last bit's low half has elapsed: release the bus.
          state_d = StFinish;
        end else if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          sh_d    = {sh_q[70:0], 1'b0};
          if (state_q == StData && !is_write_q) begin
            fv_d = {fv_q[30:0], miso};
          end
          if (state_q != StData && bit_cnt_q == bit_len - 6'd1) begin
            bit_cnt_d = 6'd0;
            unique case (state_q)
              StCmd:   state_d = StAddr;
              StAddr:  state_d = (FastRead && !is_write_q) ? StDummy : StData;
              default: state_d = StData;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StFinish: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      StDone: begin
        if (!start_request) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    cs_active = (state_d == StCmd) || (state_d == StAddr) ||
                (state_d == StDummy) || (state_d == StData);
    cs1_d     = ~(cs_active & ~chip_d);
    cs2_d     = ~(cs_active & chip_d);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 6'd0;
      phase_q    <= 1'b0;
      sh_q       <= 72'h0;
      is_write_q <= 1'b0;
      nbytes_q   <= 3'd0;
      chip_q     <= 1'b0;
      fv_q       <= 32'h0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs1_q      <= 1'b1;
      cs2_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      sh_q       <= sh_d;
      is_write_q <= is_write_d;
      nbytes_q   <= nbytes_d;
      chip_q     <= chip_d;
      fv_q       <= fv_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      cs1_q      <= cs1_d;
      cs2_q      <= cs2_d;
    end
  end

  assign fetched_value = fv_q;
  assign request_done  = done_q;
  assign sclk          = sclk_q;
  assign mosi          = sh_q[71];
  assign cs1           = cs1_q;
  assign cs2           = cs2_q;

endmodule
